// File: rtl/proc_pkg.sv
// Shared definitions for the 4-register, 4-bit processor datapath:
// opcodes, instruction field positions and the execute/writeback states.
package proc_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int REG_AW_DEF = 2;
  localparam int INSTR_W    = 8;

  // Instruction layout: [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2
  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 4;
  localparam int RS1_HI = 3;
  localparam int RS1_LO = 2;
  localparam int RS2_HI = 1;
  localparam int RS2_LO = 0;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_4b.sv
// Combinational ALU: ADD/SUB/XOR/LDI with zero and carry/borrow outputs.
module alu_4b
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] res_o,
  output logic              zero_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum     = '0;
    res_o   = '0;
    carry_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        sum     = {1'b0, a_i} + {1'b0, b_i};
        res_o   = sum[DATA_W-1:0];
        carry_o = sum[DATA_W];
      end
      OP_SUB: begin
        res_o   = a_i - b_i;
        carry_o = (a_i < b_i);
      end
      OP_XOR: res_o = a_i ^ b_i;
      default: res_o = imm_i; // LDI ignores the read data
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule

// File: rtl/exec_writeback_unit.sv
// Three-state execute/writeback controller: latches one instruction, executes it
// against combinational register-file read data, then pulses the write port.
module exec_writeback_unit
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high only in IDLE and out of reset.
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [REG_AW-1:0]  rs1_addr,
  output logic [REG_AW-1:0]  rs2_addr,
  input  logic [DATA_W-1:0]  rs1_data,
  input  logic [DATA_W-1:0]  rs2_data,
  output logic               rf_we,
  output logic [REG_AW-1:0]  rf_rd_addr,
  output logic [DATA_W-1:0]  rf_rd_data,
  output logic               flag_zero,
  output logic               flag_carry,
  output logic               retire,
  output logic [CNT_W-1:0]   retire_count,
  output logic [1:0]         dbg_state_o
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               rf_we_q, rf_we_d;
  logic [REG_AW-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               retire_q, retire_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DATA_W-1:0]  alu_res;
  logic               alu_zero;
  logic               alu_carry;

  alu_4b #(.DATA_W(DATA_W)) u_alu (
    .op_i    (ir_q[OP_HI:OP_LO]),
    .a_i     (rs1_data),
    .b_i     (rs2_data),
    .imm_i   (ir_q[RS1_HI:RS2_LO]),
    .res_o   (alu_res),
    .zero_o  (alu_zero),
    .carry_o (alu_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      rf_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      retire_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      rf_we_q   <= rf_we_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      retire_q  <= retire_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    rf_we_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    retire_d  = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Write pulse and retire are registered so they are high throughout WB
        rd_data_d = alu_res;
        rd_addr_d = ir_q[RD_HI:RD_LO];
        zero_d    = alu_zero;
        carry_d   = alu_carry;
        rf_we_d   = 1'b1;
        retire_d  = 1'b1;
        state_d   = WB;
      end
      WB: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_ready  = (state_q == IDLE) && !reset;
  assign rs1_addr     = ir_q[RS1_HI:RS1_LO];
  assign rs2_addr     = ir_q[RS2_HI:RS2_LO];
  assign rf_we        = rf_we_q;
  assign rf_rd_addr   = rd_addr_q;
  assign rf_rd_data   = rd_data_q;
  assign flag_zero    = zero_q;
  assign flag_carry   = carry_q;
  assign retire       = retire_q;
  assign retire_count = cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_exec_writeback_unit.sv
// Bench for exec_writeback_unit: register file model, accept observer with
// reference model feeding a scoreboard queue, and an independent write monitor.
module tb_exec_writeback_unit;
  import proc_pkg::*;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int CW = 8;
  localparam int EW = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [7:0]    instr = 8'h00;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic [DW-1:0] rs1_data, rs2_data;
  logic          rf_we;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic          flag_zero, flag_carry;
  logic          retire;
  logic [CW-1:0] retire_count;
  logic [1:0]    dbg_state;

  exec_writeback_unit #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .rf_we        (rf_we),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .retire       (retire),
    .retire_count (retire_count),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- register file (reset contents r0=2 r1=0 r2=3 r3=0) ----------------
  logic [DW-1:0] regs [4];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs[0] <= 4'd2;
      regs[1] <= 4'd0;
      regs[2] <= 4'd3;
      regs[3] <= 4'd0;
    end else if (rf_we) begin
      regs[rf_rd_addr] <= rf_rd_data;
    end
  end
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q [$];
  int mdl_regs [4];
  int mdl_cnt = 0;
  int acc_total = 0;
  int last_acc = 0;
  bit have_acc = 0;
  bit cnt_pending = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    mdl_regs[0] = 2;
    mdl_regs[1] = 0;
    mdl_regs[2] = 3;
    mdl_regs[3] = 0;
  endtask

  // Instruction semantics from the ISA rules, using plain integer arithmetic
  task automatic model_exec(input logic [7:0] ins, output int res, output bit z, output bit c);
    int a, b, op;
    op = int'(ins[7:6]);
    a  = mdl_regs[ins[3:2]];
    b  = mdl_regs[ins[1:0]];
    c  = 0;
    case (op)
      0: begin res = (a + b) % 16; c = (a + b) > 15; end
      1: begin res = (a - b + 16) % 16; c = a < b; end
      2: res = a ^ b;
      default: res = int'(ins[3:0]);
    endcase
    z = (res == 0);
  endtask

  // ---------------- accept observer + reference model ----------------
  always @(negedge clk) begin
    bit exp_ready;
    int res;
    bit z, c;
    if (!reset) begin
      exp_ready = !(have_acc && (cyc - last_acc) <= 2);
      check("instr_ready", 40'(instr_ready), 40'(exp_ready));
      if (instr_valid && exp_ready) begin
        model_exec(instr, res, z, c);
        exp_q.push_back({32'(cyc + 2), 2'(instr[5:4]), 4'(res), z, c});
        mdl_regs[instr[5:4]] = res;
        last_acc = cyc;
        have_acc = 1;
        acc_total++;
      end
    end
  end

  // ---------------- write monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset) begin
      check("retire_eq_we", 40'(retire), 40'(rf_we));
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          check("spurious_we", 40'(rf_we), 40'(0));
        end else begin
          e = exp_q.pop_front();
          check("wb_cycle", 40'(cyc), 40'(e[39:8]));
          check("rd_addr", 40'(rf_rd_addr), 40'(e[7:6]));
          check("rd_data", 40'(rf_rd_data), 40'(e[5:2]));
          check("flag_zero", 40'(flag_zero), 40'(e[1]));
          check("flag_carry", 40'(flag_carry), 40'(e[0]));
          mdl_cnt++;
          cnt_pending = 1;
        end
      end else if (cnt_pending) begin
        check("retire_count", 40'(retire_count), 40'(mdl_cnt % 256));
        cnt_pending = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    exp_q.delete();
    model_init();
    have_acc = 0;
    mdl_cnt = 0;
    acc_total = 0;
    cnt_pending = 0;
    #2;
    reset = 1'b0;
  endtask

  task automatic issue(input logic [7:0] ins);
    bit done;
    done = 0;
    instr_valid = 1'b1;
    instr = ins;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      check("accept_timeout", 40'(0), 40'(1));
      instr_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 40'(exp_q.size()), 40'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_init();
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    check("reset_state", 40'(dbg_state), 40'(IDLE));
    check("reset_count", 40'(retire_count), 40'(0));
    check("reset_flags", 40'({flag_zero, flag_carry}), 40'(0));
    check("reset_we", 40'({rf_we, rf_rd_addr, rf_rd_data}), 40'(0));
    @(posedge clk);
    #1;

    // Directed sequence: ADD, SUB, XOR, LDI then dependent ADD
    issue(8'h12);
    issue(8'h72);
    issue(8'h90);
    issue(8'hFF);
    issue(8'h1E);
    drain();
    check("dep_add_reg1", 40'(regs[1]), 40'(2));

    // Valid held high, instr changing every cycle
    instr_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      instr = 8'($urandom);
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    drain();

    // Random valid toggling
    for (int i = 0; i < 150; i++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      instr = 8'($urandom);
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    drain();

    // Idle with valid low stays idle
    repeat (5) @(posedge clk);
    #1;
    check("idle_hold", 40'(dbg_state), 40'(IDLE));

    // Reset during EXEC aborts the write
    issue(8'h12);
    check("in_exec", 40'(dbg_state), 40'(EXEC));
    pulse_reset();
    repeat (4) @(negedge clk);
    check("abort_state", 40'(dbg_state), 40'(IDLE));
    check("abort_flags", 40'({flag_zero, flag_carry}), 40'(0));
    check("abort_count", 40'(retire_count), 40'(0));
    check("abort_r1", 40'(regs[1]), 40'(0));
    @(posedge clk);
    #1;

    // 256 retires wrap the counter
    instr_valid = 1'b1;
    for (int i = 0; i < 2000 && acc_total < 256; i++) begin
      instr = 8'($urandom);
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    if (acc_total < 256) check("wrap_timeout", 40'(acc_total), 40'(256));
    drain();
    check("wrap_total", 40'(mdl_cnt), 40'(256));
    check("wrap_count", 40'(retire_count), 40'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
